fnd_bcd_scanner: RTL and testbench
==================================

# fnd_bcd_scanner

Display back end for the 4-digit FND path. Takes the 32-bit binary count produced by the counter stage, converts it to four BCD digits with a sequential shift-add-3 (double-dabble) converter, and time-multiplexes the digits onto a common-anode 7-segment module. The counter stage sits directly upstream; the FND pins sit directly downstream.

## Interface
- SCAN_DIV, 100_000: i_clk cycles each digit stays enabled; legal range ≥ 2.
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_value  in  32  binary value to display, sampled on an accepted load.
- i_load  in  1  load strobe; accepted only while o_busy = 0.
- o_busy  out  1  conversion in progress.
- o_bcd  out  16  committed BCD digits: [15:12] thousands … [3:0] ones.
- o_com  out  4  digit enables, active-low; o_com[0] = ones digit.
- o_seg  out  8  segments, active-low; [7] = dp, [6:0] = g..a.

## Operation
- Converter FSM states:
  - IDLE: i_load = 1 → capture sat = (i_value > 9999) ? 9999 : i_value[13:0] into a 14-bit shift register; clear the 16-bit work register and the shift count; go to CONV.
  - CONV: each cycle, add 3 to every work nibble ≥ 5, then shift {work, shift} left by 1; after 14 shifts go to COMMIT.
  - COMMIT: o_bcd ← work; go to IDLE.
- o_busy = 1 in CONV and COMMIT. i_load during busy is ignored, not queued.
- Saturation: any i_value ≥ 10000, including 0xFFFF_FFFF, gives o_bcd = 0x9999.
- Scanner runs independently of the converter:
  - Prescaler counts 0..SCAN_DIV-1 and wraps.
  - On the wrap edge, a 2-bit digit index increments 0→1→2→3→0.
- Output register, updated every cycle:
  - o_com = ~(4'b0001 << index).
  - o_seg = decode(o_bcd nibble[index]).
- Decode table, dp always off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
- Nibble values A–F cannot occur; decode them as blank (FF).
- o_bcd changes only in COMMIT, so the display never shows a partially converted value.

## Timing
- Reset values: o_seg = 8'hFF, o_com = 4'hF, o_busy = 0, o_bcd = 16'h0000, index = 0, prescaler = 0, FSM = IDLE.
- First rising edge after reset release: o_com = 4'b1110, o_seg = C0.
- Load accepted at edge 0 → o_busy = 1 after edge 0.
- 14 CONV edges, then COMMIT. o_busy falls and o_bcd updates on edge 15, so o_busy is high for exactly 15 cycles.
- A new i_load is accepted in the first cycle o_busy = 0.
- Display latency: a new o_bcd appears on o_seg 1 cycle after commit, for whichever digit is currently enabled.
- Digit index advances every SCAN_DIV cycles; o_com/o_seg follow 1 cycle after the prescaler wrap edge.
- Reset mid-conversion aborts immediately: o_bcd = 0, FSM = IDLE; the partial result is discarded.
- i_load asserted in the same cycle as COMMIT is ignored.

## Configuration
- FND_LEAD_ZERO_BLANK_EN defined: leading zero digits in positions 3..1 decode as blank (FF). The ones digit is always shown. Example: 0x0070 → blank, blank, 7, 0.
- Not defined: all four digits are always shown, including leading zeros.
- Blanking is applied in the output decode only; o_bcd is unaffected.

## Test plan
All scenarios use SCAN_DIV = 4.

- Reset, then release → during reset o_seg = FF, o_com = F, o_busy = 0. First edge after release: o_com = 1110, o_seg = C0. o_com steps to 1101 four cycles later.
- i_load with i_value = 1234 → o_busy high for exactly 15 cycles; o_bcd = 0x1234. Scan sequence: 1110/99, 1101/B0, 1011/A4, 0111/F9.
- i_value = 12345, then i_value = 0xFFFF_FFFF → o_bcd = 0x9999 both times. i_value = 9999 → 0x9999. i_value = 0 → 0x0000.
- Load 1234, then pulse i_load with 5678 on busy cycle 5 → o_bcd = 0x1234. The next load after o_busy falls gives 0x5678.
- Load 7 with FND_LEAD_ZERO_BLANK_EN defined → digits 3..1 show FF, digit 0 shows F8. Without the macro → C0, C0, C0, F8.
- Load 4321, assert i_reset on busy cycle 7 → o_busy = 0, o_bcd = 0x0000, o_seg = FF, o_com = F immediately. After release, load 4321 again → o_bcd = 0x4321.

Source files
------------

// File: rtl/fnd_bcd_scanner.sv
// 4-digit FND back end: saturating double-dabble binary-to-BCD converter plus a
// common-anode digit scanner. Define FND_LEAD_ZERO_BLANK_EN to blank leading zeros.
module fnd_bcd_scanner #(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_value,
  input  logic        i_load,
  output logic        o_busy,
  output logic [15:0] o_bcd,
  output logic [3:0]  o_com,
  output logic [7:0]  o_seg
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t      state;
  logic [13:0] shreg;
  logic [15:0] work;
  logic [15:0] adj;
  logic [3:0]  cnt;

  always_comb begin
    adj = work;
    for (int unsigned n = 0; n < 4; n++) begin
      if (work[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = work[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      shreg  <= '0;
      work   <= '0;
      cnt    <= '0;
      o_busy <= 1'b0;
      o_bcd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_load) begin
            shreg  <= (i_value > 32'd9999) ? 14'd9999 : i_value[13:0];
            work   <= '0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          // {work, shreg} shifted left as one 30-bit register after the add-3 step
          work  <= {adj[14:0], shreg[13]};
          shreg <= {shreg[12:0], 1'b0};
          cnt   <= cnt + 4'd1;
          if (cnt == 4'd13) state <= COMMIT;
        end
        COMMIT: begin
          o_bcd  <= work;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [PW-1:0] presc;
  logic [1:0]    idx;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  logic [3:0] nib;
  logic       blank;
  logic [7:0] seg_next;

  always_comb begin
    nib   = o_bcd[3:0];
    blank = 1'b0;
    case (idx)
      2'd0: nib = o_bcd[3:0];
      2'd1: nib = o_bcd[7:4];
      2'd2: nib = o_bcd[11:8];
      default: nib = o_bcd[15:12];
    endcase
`ifdef FND_LEAD_ZERO_BLANK_EN
    // A digit is blank only when it and every more-significant digit are zero
    case (idx)
      2'd1: blank = (o_bcd[15:4] == 12'd0);
      2'd2: blank = (o_bcd[15:8] == 8'd0);
      2'd3: blank = (o_bcd[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
`endif
    case (nib)
      4'd0: seg_next = 8'hC0;
      4'd1: seg_next = 8'hF9;
      4'd2: seg_next = 8'hA4;
      4'd3: seg_next = 8'hB0;
      4'd4: seg_next = 8'h99;
      4'd5: seg_next = 8'h92;
      4'd6: seg_next = 8'h82;
      4'd7: seg_next = 8'hF8;
      4'd8: seg_next = 8'h80;
      4'd9: seg_next = 8'h90;
      default: seg_next = 8'hFF;
    endcase
    if (blank) seg_next = 8'hFF;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_com <= '1;
      o_seg <= '1;
    end else begin
      o_com <= ~(4'b0001 << idx);
      o_seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_fnd_bcd_scanner.sv
// Scoreboard bench for fnd_bcd_scanner with SCAN_DIV = 4.
module tb_fnd_bcd_scanner;

  logic        clk;
  logic        reset;
  logic [31:0] value;
  logic        load;
  logic        busy;
  logic [15:0] bcd;
  logic [3:0]  com;
  logic [7:0]  seg;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] disp_bcd = 16'h0000;
  int          k;

  fnd_bcd_scanner #(.SCAN_DIV(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_value(value), .i_load(load),
    .o_busy(busy), .o_bcd(bcd), .o_com(com), .o_seg(seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // edges since reset release; digit index shown after edge k is ((k-1)/4)%4
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else       k <= k + 1;
  end

  function automatic logic [7:0] seg_of(input logic [15:0] b, input int idx);
    logic [3:0] n;
    n = 4'((b >> (4 * idx)) & 16'hF);
`ifdef FND_LEAD_ZERO_BLANK_EN
    if (idx == 3 && b[15:12] == 4'd0) return 8'hFF;
    if (idx == 2 && b[15:8] == 8'd0) return 8'hFF;
    if (idx == 1 && b[15:4] == 12'd0) return 8'hFF;
`endif
    case (n)
      4'd0: return 8'hC0; 4'd1: return 8'hF9; 4'd2: return 8'hA4;
      4'd3: return 8'hB0; 4'd4: return 8'h99; 4'd5: return 8'h92;
      4'd6: return 8'h82; 4'd7: return 8'hF8; 4'd8: return 8'h80;
      4'd9: return 8'h90; default: return 8'hFF;
    endcase
  endfunction

  task automatic start_load(input logic [31:0] v, input logic [15:0] e);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; load = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (seg !== 8'hFF || com !== 4'hF || busy !== 1'b0 || bcd !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: seg=%h com=%b busy=%b bcd=%h, want FF 1111 0 0000", seg, com, busy, bcd);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (com !== 4'b1110 || seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL first_edge: com=%b seg=%h, want 1110 C0", com, seg);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (com !== 4'b1110) begin
      n_fail++;
      $display("FAIL hold_digit0: com=%b, want 1110", com);
    end
    @(negedge clk);
    n_checks++;
    if (com !== 4'b1101 || seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL step_digit1: com=%b seg=%h, want 1101 C0", com, seg);
    end
  endtask

  task automatic test_convert(input logic [31:0] v, input logic [15:0] e, input string name);
    int cyc;
    logic [15:0] want;
    start_load(v, e);
    wait_idle(cyc);
    n_checks++;
    if (cyc !== 15) begin
      n_fail++;
      $display("FAIL %s_busy_len: got %0d cycles, want 15", name, cyc);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s_scoreboard: queue empty, want one entry", name);
    end else begin
      want = exp_q.pop_front();
      if (bcd !== want) begin
        n_fail++;
        $display("FAIL %s_bcd: got %h, want %h", name, bcd, want);
      end
      disp_bcd = want;
    end
  endtask

  task automatic test_scan(input string name);
    int idx;
    logic [3:0] ecom;
    logic [7:0] eseg;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idx  = ((k - 1) / 4) % 4;
      ecom = ~(4'b0001 << idx);
      eseg = seg_of(disp_bcd, idx);
      n_checks++;
      if (com !== ecom || seg !== eseg) begin
        n_fail++;
        $display("FAIL %s_scan: com=%b seg=%h, want %b %h", name, com, seg, ecom, eseg);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int cyc;
    logic [15:0] want;
    start_load(32'd1234, 16'h1234);
    cyc = 0;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (cyc == 5) begin value = 32'd5678; load = 1'b1; end
      else if (cyc == 15) begin value = 32'd42; load = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    n_checks++;
    if (cyc !== 15) begin
      n_fail++;
      $display("FAIL ignore_busy_len: got %0d cycles, want 15", cyc);
    end
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
    n_checks++;
    if (bcd !== want) begin
      n_fail++;
      $display("FAIL ignore_bcd: got %h, want %h", bcd, want);
    end
    disp_bcd = want;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_load_ignored: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    start_load(32'd1234, 16'h1234);
    wait_idle(cyc);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    test_convert(32'd5678, 16'h5678, "b2b");
  endtask

  task automatic test_reset_mid;
    int cyc;
    start_load(32'd4321, 16'h4321);
    cyc = 1;
    while (cyc < 7) begin cyc++; @(negedge clk); end
    reset = 1'b1;
    exp_q.delete();
    #1;
    n_checks++;
    if (busy !== 1'b0 || bcd !== 16'h0 || seg !== 8'hFF || com !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b bcd=%h seg=%h com=%b, want 0 0000 FF 1111", busy, bcd, seg, com);
    end
    disp_bcd = 16'h0;
    @(negedge clk);
    reset = 1'b0;
    test_convert(32'd4321, 16'h4321, "after_reset");
  endtask

  initial begin
    test_reset;
    test_convert(32'd1234, 16'h1234, "v1234");
    test_scan("v1234");
    test_convert(32'd12345, 16'h9999, "v12345");
    test_convert(32'hFFFF_FFFF, 16'h9999, "vmax");
    test_convert(32'd10000, 16'h9999, "v10000");
    test_convert(32'd9999, 16'h9999, "v9999");
    test_convert(32'd0, 16'h0000, "v0");
    test_busy_ignore;
    test_back_to_back;
    test_convert(32'd7, 16'h0007, "v7");
    test_scan("v7");
    test_convert(32'd70, 16'h0070, "v70");
    test_scan("v70");
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
